tone_generator: RTL and testbench

//  Consumer end of the input driver's note interface (divider, mode, strobe).

---
 rtl/tone_if.sv | 21 ++
 rtl/tone_generator.sv | 107 ++++++++++
 tb/tb_tone_generator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tone_if.sv
// Note bus from the input driver to the tone generator.
// Carries divider (clocks per phase step), mode (wave shape), strobe (key held).
interface tone_if #(
  parameter int DIV_W = 18
);
  logic [DIV_W-1:0] divider;
  logic [1:0]       mode;
  logic             strobe;

  modport master (
    output divider,
    output mode,
    output strobe
  );

  modport slave (
    input divider,
    input mode,
    input strobe
  );
endinterface

// File: rtl/tone_generator.sv
// Tone generator: divider-paced 8-bit phase, four wave shapes, PWM output.
// Ports: clk, rst (async high), i_note (tone_if.slave),
//   o_sample (8b waveform), o_step (phase advance pulse), o_pwm_out (speaker).
module tone_generator #(
  parameter int PWM_W = 8,
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  tone_if.slave            i_note,
  output logic [PWM_W-1:0] o_sample,
  output logic             o_step,
  output logic             o_pwm_out
);

  logic [DIV_W-1:0] r_div_q;
  logic [1:0]       r_mode_q;
  logic             r_active_q;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_phase;
  logic [PWM_W-1:0] r_sample;
  logic             r_step;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm_out;

  logic [DIV_W-1:0] w_div_m1;
  logic             w_wrap;
  logic [7:0]       w_wave;
  logic [7:0]       w_tri_up;

  assign w_div_m1 = r_div_q - DIV_W'(1);
  // >= so a divider that shrinks mid-count wraps at once
  assign w_wrap   = (r_cnt >= w_div_m1);
  assign w_tri_up = {r_phase[6:0], 1'b0};

  always_comb begin
    w_wave = 8'h00;
    if (r_active_q) begin
      unique case (r_mode_q)
        2'd0: w_wave = r_phase[7] ? 8'h00 : 8'hFF;
        2'd1: w_wave = r_phase;
        2'd2: w_wave = r_phase[7] ? ~w_tri_up : w_tri_up;
        2'd3: w_wave = (r_phase[7:6] == 2'b00) ? 8'hFF : 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_q    <= '0;
      r_mode_q   <= '0;
      r_active_q <= 1'b0;
    end else begin
      r_div_q    <= i_note.divider;
      r_mode_q   <= i_note.mode;
      r_active_q <= i_note.strobe && (i_note.divider != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= '0;
      r_step  <= 1'b0;
    end else if (!r_active_q) begin
      r_cnt   <= '0;
      r_phase <= '0;
      r_step  <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 8'd1;
      r_step  <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + DIV_W'(1);
      r_step  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
    end else begin
      r_sample <= PWM_W'(w_wave);
    end
  end

  // duty is reloaded only at the wrap so a period never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_pwm_out <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (r_pwm_cnt == '1) begin
        r_duty <= r_sample;
      end
      r_pwm_out <= (r_pwm_cnt < r_duty);
    end
  end

  assign o_sample  = r_sample;
  assign o_step    = r_step;
  assign o_pwm_out = r_pwm_out;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator.
// Vector table plus hand sequences for PWM and async reset.
module tb_tone_generator;

  logic       clk;
  logic       rst;
  logic [7:0] sample;
  logic       step;
  logic       pwm_out;

  tone_if #(.DIV_W(18)) nif ();

  tone_generator #(
    .PWM_W(8),
    .DIV_W(18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_note    (nif.slave),
    .o_sample  (sample),
    .o_step    (step),
    .o_pwm_out (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [17:0] div;
    logic [1:0]  mode;
    logic        strobe;
    int          cyc;
    logic [7:0]  smp;
    logic        stp;
    logic        cpwm;
    logic        pwm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  task automatic add(
    input string nm, input logic r,
    input logic [17:0] d, input logic [1:0] m,
    input logic s, input int c,
    input logic [7:0] es, input logic ep,
    input logic cp, input logic ew
  );
    vec_t v;
    v.name = nm; v.rst = r; v.div = d;
    v.mode = m; v.strobe = s; v.cyc = c;
    v.smp = es; v.stp = ep;
    v.cpwm = cp; v.pwm = ew;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  int hi_cnt;
  int first_hi;
  int last_hi;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    nif.divider = 18'd4;
    nif.mode = 2'd1;
    nif.strobe = 1'b1;

    // reset hold, sawtooth pacing and wrap
    add("rst_hold",  1,4,1,1,3,  8'd0,  0,1,0);
    add("pre_step",  0,4,1,1,4,  8'd0,  0,1,0);
    add("first_stp", 0,4,1,1,1,  8'd0,  1,0,0);
    add("saw1",      0,4,1,1,1,  8'd1,  0,0,0);
    add("step2",     0,4,1,1,3,  8'd1,  1,0,0);
    add("saw2",      0,4,1,1,1,  8'd2,  0,0,0);
    add("saw100",    0,4,1,1,392,8'd100,0,0,0);
    add("saw255",    0,4,1,1,623,8'd255,1,0,0);
    add("saw_wrap",  0,4,1,1,1,  8'd0,  0,0,0);
    // triangle, square, pulse at divider 1
    add("rst_tri",   1,1,2,1,1,  8'd0,  0,1,0);
    add("tri0",      0,1,2,1,2,  8'd0,  1,0,0);
    add("tri2",      0,1,2,1,1,  8'd2,  1,0,0);
    add("tri254",    0,1,2,1,126,8'd254,1,0,0);
    add("tri255",    0,1,2,1,1,  8'd255,1,0,0);
    add("tri1",      0,1,2,1,127,8'd1,  1,0,0);
    add("tri_wrap",  0,1,2,1,1,  8'd0,  1,0,0);
    add("mode_lag",  0,1,0,1,1,  8'd2,  1,0,0);
    add("sq_ff",     0,1,0,1,1,  8'hFF, 1,0,0);
    add("sq_ff_end", 0,1,0,1,125,8'hFF, 1,0,0);
    add("sq_00",     0,1,0,1,1,  8'h00, 1,0,0);
    add("sq_00_end", 0,1,0,1,127,8'h00, 1,0,0);
    add("sq_wrap",   0,1,0,1,1,  8'hFF, 1,0,0);
    add("pulse_ff",  0,1,3,1,63, 8'hFF, 1,0,0);
    add("pulse_00",  0,1,3,1,1,  8'h00, 1,0,0);
    // divider 0 is silence
    add("rst_div0",  1,0,1,1,1,  8'd0,  0,1,0);
    add("div0",      0,0,1,1,20, 8'd0,  0,1,0);
    // divider shrinks 100->3 mid-count
    add("rst_d100",  1,100,1,1,1,8'd0,  0,1,0);
    add("d100_c50",  0,100,1,1,50,8'd0, 0,0,0);
    add("d3_nostep", 0,3,1,1,1,  8'd0,  0,0,0);
    add("d3_step",   0,3,1,1,1,  8'd0,  1,0,0);
    add("d3_gap",    0,3,1,1,2,  8'd1,  0,0,0);
    add("d3_step2",  0,3,1,1,1,  8'd1,  1,0,0);
    // release and restart from phase 0
    add("rel1",      0,3,1,0,1,  8'd2,  0,0,0);
    add("rel2",      0,3,1,0,1,  8'd0,  0,0,0);
    add("restart",   0,3,1,1,4,  8'd0,  1,0,0);
    add("restart_ph",0,3,1,1,1,  8'd1,  0,0,0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      nif.divider = tbl[i].div;
      nif.mode = tbl[i].mode;
      nif.strobe = tbl[i].strobe;
      repeat (tbl[i].cyc) tick();
      chk({tbl[i].name, ".sample"},
          32'(sample), 32'(tbl[i].smp));
      chk({tbl[i].name, ".step"},
          32'(step), 32'(tbl[i].stp));
      if (tbl[i].cpwm)
        chk({tbl[i].name, ".pwm"},
            32'(pwm_out), 32'(tbl[i].pwm));
    end

    // PWM: freeze sawtooth at 64
    rst = 1'b1;
    nif.divider = 18'd1;
    nif.mode = 2'd1;
    nif.strobe = 1'b1;
    tick();
    rst = 1'b0;
    repeat (64) tick();
    nif.divider = 18'd200000;
    repeat (192) tick();
    chk("pwm.sample64", 32'(sample), 32'd64);
    chk("pwm.pre_low", 32'(pwm_out), 32'd0);
    hi_cnt = 0;
    first_hi = -1;
    last_hi = -1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
    end
    chk("pwm.high_cnt", 32'(hi_cnt), 32'd64);
    chk("pwm.first_hi", 32'(first_hi), 32'd0);
    chk("pwm.last_hi", 32'(last_hi), 32'd63);
    repeat (10) tick();
    chk("pwm.mid_hi", 32'(pwm_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.pwm", 32'(pwm_out), 32'd0);
    chk("arst.sample", 32'(sample), 32'd0);
    chk("arst.step", 32'(step), 32'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
